// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared pipeline widths and the MEM/WB entry layout
package pipe_pkg;

   localparam int DATA_W = 32;
   localparam int ADDR_W = 5;

   typedef struct packed {
      logic [DATA_W-1:0] dm_data;
      logic [DATA_W-1:0] alu_result;
      logic [ADDR_W-1:0] write_addr;
      logic              mem_to_reg;
      logic              reg_write;
   } wb_entry_t;

endpackage

// File: rtl/pipe_skid_buf.sv
// rtl/pipe_skid_buf.sv - two-entry skid buffer (main drives the outputs, skid absorbs one stall)
module pipe_skid_buf
   import pipe_pkg::*;
#(
   parameter type entry_t = wb_entry_t
) (
   input  logic   clk,
   input  logic   rst,
   input  logic   flush,
   input  logic   in_valid,
   output logic   in_ready,
   input  entry_t in_data,
   output logic   out_valid,
   input  logic   out_ready,
   output entry_t out_data
);

   logic   main_valid;
   logic   skid_valid;
   entry_t main_q;
   entry_t skid_q;
   logic   accept;
   logic   drain;

   assign in_ready  = !skid_valid && !rst;
   assign accept    = in_valid && in_ready;
   assign drain     = main_valid && out_ready;
   assign out_valid = main_valid;
   assign out_data  = main_q;

   // Stored data is left untouched on flush/drain so the outputs hold their last value.
   always_ff @(posedge clk) begin
      if (rst) begin
         main_valid <= 1'b0;
         skid_valid <= 1'b0;
         main_q     <= '0;
         skid_q     <= '0;
      end else if (flush) begin
         main_valid <= 1'b0;
         skid_valid <= 1'b0;
      end else if (drain) begin
         if (skid_valid) begin
            main_q     <= skid_q;
            skid_valid <= 1'b0;
         end else if (accept) begin
            main_q <= in_data;
         end else begin
            main_valid <= 1'b0;
         end
      end else if (!main_valid) begin
         if (accept) begin
            main_q     <= in_data;
            main_valid <= 1'b1;
         end
      end else if (accept) begin
         skid_q     <= in_data;
         skid_valid <= 1'b1;
      end
   end

endmodule

// File: rtl/mem_wb_stage.sv
// rtl/mem_wb_stage.sv - MEM/WB pipeline register with skid buffering; MEM_WB_FWD_EN adds forwarding ports
module mem_wb_stage #(
   parameter int DATA_W = pipe_pkg::DATA_W,
   parameter int ADDR_W = pipe_pkg::ADDR_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] dm_data_in,
   input  logic [DATA_W-1:0] alu_result_in,
   input  logic [ADDR_W-1:0] write_addr_in,
   input  logic              mem_to_reg_in,
   input  logic              reg_write_in,
   input  logic              flush,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] dm_data_out,
   output logic [DATA_W-1:0] alu_result_out,
   output logic [ADDR_W-1:0] write_addr_out,
   output logic              mem_to_reg_out,
`ifdef MEM_WB_FWD_EN
   input  logic [ADDR_W-1:0] rs_addr,
   input  logic [ADDR_W-1:0] rt_addr,
   output logic [DATA_W-1:0] wb_data_out,
   output logic              fwd_rs_hit,
   output logic              fwd_rt_hit,
`endif
   output logic              reg_write_out
);

   import pipe_pkg::*;

   // Same layout as wb_entry_t, but tracking this instance's widths.
   typedef struct packed {
      logic [DATA_W-1:0] dm_data;
      logic [DATA_W-1:0] alu_result;
      logic [ADDR_W-1:0] write_addr;
      logic              mem_to_reg;
      logic              reg_write;
   } stage_entry_t;

   stage_entry_t cap_entry;
   stage_entry_t main_entry;

   // Register x0 is hardwired, so a write to it is dropped at capture.
   always_comb begin
      cap_entry            = '0;
      cap_entry.dm_data    = dm_data_in;
      cap_entry.alu_result = alu_result_in;
      cap_entry.write_addr = write_addr_in;
      cap_entry.mem_to_reg = mem_to_reg_in;
      cap_entry.reg_write  = reg_write_in && (write_addr_in != '0);
   end

   pipe_skid_buf #(
      .entry_t (stage_entry_t)
   ) u_skid (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (cap_entry),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (main_entry)
   );

   assign dm_data_out    = main_entry.dm_data;
   assign alu_result_out = main_entry.alu_result;
   assign write_addr_out = main_entry.write_addr;
   assign mem_to_reg_out = main_entry.mem_to_reg;
   assign reg_write_out  = main_entry.reg_write && out_valid;

`ifdef MEM_WB_FWD_EN
   assign wb_data_out = main_entry.mem_to_reg ? main_entry.dm_data : main_entry.alu_result;
   assign fwd_rs_hit  = reg_write_out && (main_entry.write_addr == rs_addr);
   assign fwd_rt_hit  = reg_write_out && (main_entry.write_addr == rt_addr);
`endif

endmodule

// File: tb/tb_mem_wb_stage.sv
// tb/tb_mem_wb_stage.sv - self-checking bench for mem_wb_stage against a 2-deep FIFO model
module tb_mem_wb_stage;

   localparam int DW = 32;
   localparam int AW = 5;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid;
   logic          in_ready;
   logic [DW-1:0] dm_data_in;
   logic [DW-1:0] alu_result_in;
   logic [AW-1:0] write_addr_in;
   logic          mem_to_reg_in;
   logic          reg_write_in;
   logic          flush;
   logic          out_valid;
   logic          out_ready;
   logic [DW-1:0] dm_data_out;
   logic [DW-1:0] alu_result_out;
   logic [AW-1:0] write_addr_out;
   logic          mem_to_reg_out;
   logic          reg_write_out;
`ifdef MEM_WB_FWD_EN
   logic [AW-1:0] rs_addr;
   logic [AW-1:0] rt_addr;
   logic [DW-1:0] wb_data_out;
   logic          fwd_rs_hit;
   logic          fwd_rt_hit;
`endif

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   mem_wb_stage #(.DATA_W(DW), .ADDR_W(AW)) dut (
      .clk            (clk),
      .rst            (rst),
      .in_valid       (in_valid),
      .in_ready       (in_ready),
      .dm_data_in     (dm_data_in),
      .alu_result_in  (alu_result_in),
      .write_addr_in  (write_addr_in),
      .mem_to_reg_in  (mem_to_reg_in),
      .reg_write_in   (reg_write_in),
      .flush          (flush),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .dm_data_out    (dm_data_out),
      .alu_result_out (alu_result_out),
      .write_addr_out (write_addr_out),
      .mem_to_reg_out (mem_to_reg_out),
`ifdef MEM_WB_FWD_EN
      .rs_addr        (rs_addr),
      .rt_addr        (rt_addr),
      .wb_data_out    (wb_data_out),
      .fwd_rs_hit     (fwd_rs_hit),
      .fwd_rt_hit     (fwd_rt_hit),
`endif
      .reg_write_out  (reg_write_out)
   );

   // Reference: an ordered queue holding at most two entries, plus the last value shown.
   typedef struct {
      logic [DW-1:0] dm;
      logic [DW-1:0] alu;
      logic [AW-1:0] addr;
      logic          m2r;
      logic          rw;
   } m_entry_t;

   m_entry_t q[$];
   m_entry_t last;

   function automatic m_entry_t blank();
      m_entry_t e;
      e.dm = '0; e.alu = '0; e.addr = '0; e.m2r = 1'b0; e.rw = 1'b0;
      return e;
   endfunction

   function automatic logic exp_in_ready();
      return !rst && (q.size() < 2);
   endfunction

   task automatic model_edge();
      m_entry_t e;
      logic acc, drn;
      if (rst) begin
         q.delete();
         last = blank();
         return;
      end
      if (flush) begin
         q.delete();
         return;
      end
      acc = in_valid && (q.size() < 2);
      drn = (q.size() > 0) && out_ready;
      if (drn) void'(q.pop_front());
      if (acc) begin
         e.dm = dm_data_in; e.alu = alu_result_in; e.addr = write_addr_in;
         e.m2r = mem_to_reg_in; e.rw = reg_write_in && (write_addr_in != 0);
         q.push_back(e);
      end
      if (q.size() > 0) last = q[0];
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      @(negedge clk);
   endtask

   task automatic drive(input logic v, input logic [DW-1:0] dm, input logic [DW-1:0] alu,
                        input logic [AW-1:0] addr, input logic m2r, input logic rw);
      in_valid = v; dm_data_in = dm; alu_result_in = alu;
      write_addr_in = addr; mem_to_reg_in = m2r; reg_write_in = rw;
   endtask

   task automatic test_reset();
      rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
      drive(1'b1, $urandom, $urandom, AW'($urandom), 1'b1, 1'b1);
`ifdef MEM_WB_FWD_EN
      rs_addr = '0; rt_addr = '0;
`endif
      step(); step();
      vectors++;
      if (in_ready !== 1'b0) begin
         miscompares++; $display("FAIL reset_in_ready got %b want 0", in_ready);
      end
      vectors++;
      if ({out_valid, dm_data_out, alu_result_out, write_addr_out, mem_to_reg_out, reg_write_out} !== '0) begin
         miscompares++;
         $display("FAIL reset_outputs got v=%b dm=%h alu=%h a=%0d m=%b rw=%b want all 0",
                  out_valid, dm_data_out, alu_result_out, write_addr_out, mem_to_reg_out, reg_write_out);
      end
      rst = 1'b0;
      drive(1'b0, '0, '0, '0, 1'b0, 1'b0);
      #1;
      vectors++;
      if (in_ready !== 1'b1) begin
         miscompares++; $display("FAIL post_reset_in_ready got %b want 1", in_ready);
      end
   endtask

   task automatic test_first_entry();
      out_ready = 1'b1;
      drive(1'b1, 32'h0, 32'h0000_1234, 5'd3, 1'b0, 1'b1);
      step();
      drive(1'b0, '0, '0, '0, 1'b0, 1'b0);
      vectors++;
      if (out_valid !== 1'b1 || alu_result_out !== 32'h1234 || reg_write_out !== 1'b1 || write_addr_out !== 5'd3) begin
         miscompares++;
         $display("FAIL first_entry got v=%b alu=%h rw=%b a=%0d want v=1 alu=1234 rw=1 a=3",
                  out_valid, alu_result_out, reg_write_out, write_addr_out);
      end
      step();
      vectors++;
      if (out_valid !== 1'b0 || alu_result_out !== 32'h1234 || reg_write_out !== 1'b0) begin
         miscompares++;
         $display("FAIL drained_hold got v=%b alu=%h rw=%b want v=0 alu=1234 rw=0",
                  out_valid, alu_result_out, reg_write_out);
      end
   endtask

   task automatic test_back_to_back();
      logic [DW-1:0] a, b;
      a = $urandom; b = $urandom;
      out_ready = 1'b0;
      drive(1'b1, '0, a, 5'd4, 1'b0, 1'b1);
      step();
      drive(1'b1, '0, b, 5'd5, 1'b0, 1'b1);
      step();
      drive(1'b0, '0, '0, '0, 1'b0, 1'b0);
      vectors++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || alu_result_out !== a) begin
         miscompares++;
         $display("FAIL b2b_full got rdy=%b v=%b alu=%h want rdy=0 v=1 alu=%h", in_ready, out_valid, alu_result_out, a);
      end
      step();
      vectors++;
      if (alu_result_out !== a || out_valid !== 1'b1) begin
         miscompares++; $display("FAIL b2b_stall_hold got alu=%h v=%b want %h v=1", alu_result_out, out_valid, a);
      end
      out_ready = 1'b1;
      step();
      vectors++;
      if (alu_result_out !== b || out_valid !== 1'b1 || in_ready !== 1'b1 || write_addr_out !== 5'd5) begin
         miscompares++;
         $display("FAIL b2b_second got alu=%h v=%b rdy=%b a=%0d want %h v=1 rdy=1 a=5",
                  alu_result_out, out_valid, in_ready, write_addr_out, b);
      end
      step();
      vectors++;
      if (out_valid !== 1'b0) begin
         miscompares++; $display("FAIL b2b_empty got v=%b want 0", out_valid);
      end
   endtask

   task automatic test_x0_rule();
      out_ready = 1'b1;
      drive(1'b1, $urandom, $urandom, 5'd0, 1'b0, 1'b1);
      step();
      drive(1'b0, '0, '0, '0, 1'b0, 1'b0);
      vectors++;
      if (out_valid !== 1'b1 || reg_write_out !== 1'b0) begin
         miscompares++; $display("FAIL x0_rule got v=%b rw=%b want v=1 rw=0", out_valid, reg_write_out);
      end
      step();
   endtask

   task automatic test_flush();
      out_ready = 1'b0;
      drive(1'b1, '0, 32'hA, 5'd1, 1'b0, 1'b1);
      step();
      drive(1'b1, '0, 32'hB, 5'd2, 1'b0, 1'b1);
      step();
      flush = 1'b1;
      drive(1'b1, '0, 32'hC, 5'd6, 1'b0, 1'b1);
      step();
      flush = 1'b0;
      drive(1'b0, '0, '0, '0, 1'b0, 1'b0);
      vectors++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || reg_write_out !== 1'b0) begin
         miscompares++;
         $display("FAIL flush got v=%b rdy=%b rw=%b want v=0 rdy=1 rw=0", out_valid, in_ready, reg_write_out);
      end
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         vectors++;
         if (out_valid !== 1'b0 || alu_result_out === 32'hC) begin
            miscompares++; $display("FAIL flush_leak cyc %0d got v=%b alu=%h want v=0", i, out_valid, alu_result_out);
         end
      end
   endtask

   task automatic test_stream();
      out_ready = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         drive(1'b1, '0, DW'(i), 5'd9, 1'b0, 1'b1);
         step();
         vectors++;
         if (out_valid !== 1'b1 || alu_result_out !== DW'(i) || in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL stream %0d got v=%b alu=%h rdy=%b want v=1 alu=%h rdy=1",
                     i, out_valid, alu_result_out, in_ready, DW'(i));
         end
      end
      drive(1'b0, '0, '0, '0, 1'b0, 1'b0);
      step();
   endtask

   task automatic test_random();
      logic exp_v;
      for (int cyc = 0; cyc < 400; cyc++) begin
         rst       = ($urandom_range(63) == 0);
         flush     = ($urandom_range(15) == 0);
         out_ready = ($urandom_range(2) != 0);
         drive($urandom_range(3) != 0, $urandom, $urandom, AW'($urandom_range(3)), 1'($urandom), 1'($urandom));
         #1;
         vectors++;
         if (in_ready !== exp_in_ready()) begin
            miscompares++; $display("FAIL rand_ready cyc %0d got %b want %b", cyc, in_ready, exp_in_ready());
         end
         step();
         exp_v = (q.size() > 0);
         vectors++;
         if (out_valid !== exp_v || dm_data_out !== last.dm || alu_result_out !== last.alu ||
             write_addr_out !== last.addr || mem_to_reg_out !== last.m2r || reg_write_out !== (last.rw && exp_v)) begin
            miscompares++;
            $display("FAIL rand_out cyc %0d got v=%b dm=%h alu=%h a=%0d m=%b rw=%b want v=%b dm=%h alu=%h a=%0d m=%b rw=%b",
                     cyc, out_valid, dm_data_out, alu_result_out, write_addr_out, mem_to_reg_out, reg_write_out,
                     exp_v, last.dm, last.alu, last.addr, last.m2r, last.rw && exp_v);
         end
      end
      rst = 1'b0; flush = 1'b0;
      drive(1'b0, '0, '0, '0, 1'b0, 1'b0);
      out_ready = 1'b1;
      step(); step(); step();
   endtask

`ifdef MEM_WB_FWD_EN
   task automatic test_forwarding();
      out_ready = 1'b0;
      rs_addr = 5'd7; rt_addr = 5'd8;
      drive(1'b1, 32'hAA, 32'h55, 5'd7, 1'b1, 1'b1);
      step();
      drive(1'b0, '0, '0, '0, 1'b0, 1'b0);
      vectors++;
      if (fwd_rs_hit !== 1'b1 || fwd_rt_hit !== 1'b0 || wb_data_out !== 32'hAA) begin
         miscompares++;
         $display("FAIL fwd got rs=%b rt=%b wb=%h want rs=1 rt=0 wb=aa", fwd_rs_hit, fwd_rt_hit, wb_data_out);
      end
      out_ready = 1'b1;
      step();
      vectors++;
      if (fwd_rs_hit !== 1'b0 || wb_data_out !== 32'hAA) begin
         miscompares++; $display("FAIL fwd_idle got rs=%b wb=%h want rs=0 wb=aa", fwd_rs_hit, wb_data_out);
      end
   endtask
`endif

   initial begin
      q.delete();
      last = blank();
      @(negedge clk);
      test_reset();
      test_first_entry();
      test_back_to_back();
      test_x0_rule();
      test_flush();
      test_stream();
`ifdef MEM_WB_FWD_EN
      test_forwarding();
`endif
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/mem_wb_stage.md
MEM_WB_STAGE -- requirements
Module: mem_wb_stage

Interface
REQ-001 Parameter DATA_W, default 32, SHALL set the width of the data-memory and ALU result paths.
REQ-002 Parameter ADDR_W, default 5, SHALL set the width of the register write address.
REQ-003 Port clk  input  1  rising-edge clock.
REQ-004 Port rst  input  1  reset; synchronous, active-high.
REQ-005 Port in_valid  input  1  upstream (MEM) entry valid.
REQ-006 Port in_ready  output  1  stage can accept an entry this cycle.
REQ-007 Port dm_data_in, alu_result_in  input  DATA_W  MEM-stage data.
REQ-008 Port write_addr_in  input  ADDR_W  destination register.
REQ-009 Port mem_to_reg_in, reg_write_in  input  1  control signals.
REQ-010 Port flush  input  1  discard all held and incoming entries.
REQ-011 Port out_valid  output  1  WB entry valid.
REQ-012 Port out_ready  input  1  WB consumes the entry this cycle.
REQ-013 Ports dm_data_out, alu_result_out (DATA_W), write_addr_out (ADDR_W), mem_to_reg_out, reg_write_out (1), all outputs: the WB entry.

Function
REQ-014 Storage SHALL be a main register (drives outputs) plus one skid register, each with its own valid bit.
REQ-015 Accept SHALL occur when in_valid && in_ready; in_ready SHALL equal !skid_valid && !rst.
REQ-016 Latency: an entry accepted with main empty, or main draining (out_valid && out_ready), SHALL appear on the outputs the next cycle.
REQ-017 Accept while main is valid and out_ready is low SHALL load the skid register; the main entry holds.
REQ-018 When main drains and skid_valid is set, main SHALL load the skid entry and clear skid_valid; an entry arriving in that same cycle is impossible (in_ready is low).
REQ-019 Order: entries SHALL leave in acceptance order with no loss or duplication.
REQ-020 Capture SHALL clear the stored reg_write when write_addr_in == 0.
REQ-021 reg_write_out SHALL equal stored reg_write && out_valid.
REQ-022 While out_valid is low, the data, address, and mem_to_reg outputs SHALL hold their last value.
REQ-023 flush SHALL clear both valid bits at the next edge and drop any entry offered in the flush cycle; flush has priority over accept and drain.
REQ-024 Simultaneous drain and accept with the skid register empty SHALL replace main with the new entry; out_valid stays high.

Reset
REQ-025 rst SHALL clear main_valid and skid_valid, and zero every output and stored field, at the next edge.
REQ-026 in_ready SHALL be low while rst is high and SHALL be high in the first cycle after rst deasserts.
REQ-027 rst asserted mid-transfer SHALL discard all entries; no partial entry SHALL survive.

Configuration
REQ-028 Macro MEM_WB_FWD_EN, when defined, SHALL add the following ports:
- rs_addr, rt_addr: inputs, ADDR_W wide.
- wb_data_out: output, DATA_W wide; equals mem_to_reg_out ? dm_data_out : alu_result_out.
- fwd_rs_hit, fwd_rt_hit: outputs, 1 bit; each equals reg_write_out && (write_addr_out == rs_addr / rt_addr).
REQ-029 Without MEM_WB_FWD_EN, these ports and their logic SHALL be absent, and the remaining behaviour SHALL be identical.

Structure
REQ-030 A shared package pipe_pkg SHALL hold:
- DATA_W and ADDR_W defaults;
- the packed entry struct wb_entry_t (dm_data, alu_result, write_addr, mem_to_reg, reg_write).
REQ-031 The block SHALL use one sub-module, pipe_skid_buf: a generic 2-entry skid buffer over wb_entry_t; mem_wb_stage adds the x0 rule, the output qualification, and the forwarding logic.

Verification
REQ-032 The bench SHALL cover the following directed scenarios:
- Reset, then in_valid=1, alu_result_in=0x0000_1234, write_addr_in=3, reg_write_in=1, out_ready=1 -> next cycle out_valid=1, alu_result_out=0x1234, reg_write_out=1; during reset all outputs 0 and in_ready=0.
- out_ready=0, two entries A, B accepted back-to-back -> in_ready falls after B; out_ready=1 -> A then B on consecutive cycles, in_ready rises.
- write_addr_in=0, reg_write_in=1 -> reg_write_out=0 with out_valid=1.
- Main and skid full, flush=1 with in_valid=1 -> next cycle out_valid=0 and in_ready=1; the flushed-cycle entry never appears.
- Streaming with out_ready=1 and in_valid=1 for 8 cycles, values 1..8 -> out_valid continuously high, outputs 1..8 in order, no stalls.
- With MEM_WB_FWD_EN: write_addr_out=7, reg_write_out=1, mem_to_reg_out=1, dm_data_out=0xAA, rs_addr=7 -> fwd_rs_hit=1, wb_data_out=0xAA.
